// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin sharing of one external 32-bit ALU between two
//            requesters, with a held response register per grant.
// Revision : 1.0
// ============================================================================
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [4:0]       i_req0_ctrl,
  input  logic [4:0]       i_req1_ctrl,
  input  logic             i_req0_sign,
  input  logic             i_req1_sign,
  input  logic [WIDTH-1:0] i_req0_in1,
  input  logic [WIDTH-1:0] i_req0_in2,
  input  logic [WIDTH-1:0] i_req1_in1,
  input  logic [WIDTH-1:0] i_req1_in2,
  output logic [4:0]       o_alu_ctrl,
  output logic             o_alu_sign,
  output logic [WIDTH-1:0] o_alu_in1,
  output logic [WIDTH-1:0] o_alu_in2,
  input  logic [WIDTH-1:0] i_alu_out,
  input  logic             i_alu_zero,
  output logic [1:0]       o_rsp_valid,
  input  logic [1:0]       i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_zero,
  output logic             o_rsp_err,
  output logic [CNT_W-1:0] o_done_cnt0,
  output logic [CNT_W-1:0] o_done_cnt1
);

  localparam logic [0:0]       c_IDLE    = 1'b0;
  localparam logic [0:0]       c_RESP    = 1'b1;
  localparam logic [4:0]       c_MAX_OP  = 5'd9;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic             r_owner;
  logic             r_prio;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_done_cnt0;
  logic [CNT_W-1:0] r_done_cnt1;

  logic w_rsp_done;
  logic w_can_accept;
  logic w_grant;
  logic w_gnt_sel;
  logic w_illegal;

  assign w_rsp_done   = (r_state == c_RESP) & i_rsp_ready[r_owner];
  assign w_can_accept = (r_state == c_IDLE) | w_rsp_done;
  // Gating with rst_n keeps the ALU inputs and ready quiet while reset is held.
  assign w_grant      = rst_n & w_can_accept & (|i_req_valid);
  assign w_gnt_sel    = (&i_req_valid) ? r_prio : i_req_valid[1];
  assign w_illegal    = (o_alu_ctrl > c_MAX_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_grant) begin
      w_state_nxt = c_RESP;
    end else if (w_rsp_done) begin
      w_state_nxt = c_IDLE;
    end
  end

  always_comb begin
    o_req_ready = 2'b00;
    o_alu_ctrl  = 5'd0;
    o_alu_sign  = 1'b0;
    o_alu_in1   = '0;
    o_alu_in2   = '0;
    o_rsp_valid = 2'b00;
    if (w_grant) begin
      o_req_ready = w_gnt_sel ? 2'b10 : 2'b01;
      o_alu_ctrl  = w_gnt_sel ? i_req1_ctrl : i_req0_ctrl;
      o_alu_sign  = w_gnt_sel ? i_req1_sign : i_req0_sign;
      o_alu_in1   = w_gnt_sel ? i_req1_in1  : i_req0_in1;
      o_alu_in2   = w_gnt_sel ? i_req1_in2  : i_req0_in2;
    end
    if (r_state == c_RESP) begin
      o_rsp_valid = r_owner ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= 1'b0;
      r_prio      <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_done_cnt0 <= '0;
      r_done_cnt1 <= '0;
    end else begin
      if (w_grant) begin
        r_owner    <= w_gnt_sel;
        r_prio     <= ~w_gnt_sel;
        // Illegal opcodes are consumed but the ALU result is discarded.
        r_rsp_data <= w_illegal ? '0 : i_alu_out;
        r_rsp_zero <= w_illegal ? 1'b0 : i_alu_zero;
        r_rsp_err  <= w_illegal;
      end
      if (w_rsp_done && !r_owner) begin
        r_done_cnt0 <= r_done_cnt0 + c_CNT_ONE;
      end
      if (w_rsp_done && r_owner) begin
        r_done_cnt1 <= r_done_cnt1 + c_CNT_ONE;
      end
    end
  end

  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_zero  = r_rsp_zero;
  assign o_rsp_err   = r_rsp_err;
  assign o_done_cnt0 = r_done_cnt0;
  assign o_done_cnt1 = r_done_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Directed vector table, corner sequences and random traffic
//            against a cycle-level reference model of the shared-ALU arbiter.
// Revision : 1.0
// ============================================================================
module tb_alu_share_arbiter;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    vld, rdy, rr, rsp_valid;
  logic [4:0]    c0, c1, alu_ctrl;
  logic          s0, s1, alu_sign, alu_zero, rsp_zero, rsp_err;
  logic [W-1:0]  a0, b0, a1, b1, alu_in1, alu_in2, alu_out, rsp_data;
  logic [CW-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(vld), .o_req_ready(rdy),
    .i_req0_ctrl(c0), .i_req1_ctrl(c1), .i_req0_sign(s0), .i_req1_sign(s1),
    .i_req0_in1(a0), .i_req0_in2(b0), .i_req1_in1(a1), .i_req1_in2(b1),
    .o_alu_ctrl(alu_ctrl), .o_alu_sign(alu_sign), .o_alu_in1(alu_in1), .o_alu_in2(alu_in2),
    .i_alu_out(alu_out), .i_alu_zero(alu_zero),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rr),
    .o_rsp_data(rsp_data), .o_rsp_zero(rsp_zero), .o_rsp_err(rsp_err),
    .o_done_cnt0(cnt0), .o_done_cnt1(cnt1)
  );

  function automatic logic [31:0] alu_fn(logic [4:0] op, logic sg, logic [31:0] x, logic [31:0] y);
    case (op)
      5'd0: return x + y;
      5'd1: return x - y;
      5'd2: return x & y;
      5'd3: return x | y;
      5'd4: return x ^ y;
      5'd5: return ~(x | y);
      5'd6: return x << y[4:0];
      5'd7: return x >> y[4:0];
      5'd8: return $signed(x) >>> y[4:0];
      5'd9: return sg ? {31'd0, $signed(x) < $signed(y)} : {31'd0, x < y};
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign alu_out  = alu_fn(alu_ctrl, alu_sign, alu_in1, alu_in2);
  assign alu_zero = (alu_out == 32'd0);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_held, m_owner, m_prio, m_zero, m_err;
  logic [31:0] m_data;
  int          m_cnt0, m_cnt1;
  logic [1:0]  last_rdy;

  task automatic model_reset();
    m_held = 0; m_owner = 0; m_prio = 0; m_zero = 0; m_err = 0;
    m_data = 0; m_cnt0 = 0; m_cnt1 = 0; last_rdy = 2'b00;
  endtask

  // Called just after a falling edge with inputs already applied; returns at the next falling edge.
  task automatic run_cycle();
    bit grant, g;
    logic [1:0] e_rdy;
    logic [4:0] ec;
    logic es;
    logic [31:0] ea, eb, r;
    #1;
    grant = (!m_held || rr[m_owner]) && (vld != 2'b00);
    g     = (vld == 2'b11) ? m_prio : vld[1];
    e_rdy = grant ? (g ? 2'b10 : 2'b01) : 2'b00;
    ec = grant ? (g ? c1 : c0) : 5'd0;
    es = grant ? (g ? s1 : s0) : 1'b0;
    ea = grant ? (g ? a1 : a0) : 32'd0;
    eb = grant ? (g ? b1 : b0) : 32'd0;
    chk("req_ready", 32'(rdy), 32'(e_rdy));
    chk("alu_ctrl", 32'(alu_ctrl), 32'(ec));
    chk("alu_sign", 32'(alu_sign), 32'(es));
    chk("alu_in1", alu_in1, ea);
    chk("alu_in2", alu_in2, eb);
    chk("rsp_valid", 32'(rsp_valid), m_held ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
    if (m_held) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    chk("done_cnt0", 32'(cnt0), 32'(m_cnt0));
    chk("done_cnt1", 32'(cnt1), 32'(m_cnt1));
    last_rdy = rdy;
    @(posedge clk);
    if (m_held && rr[m_owner]) begin
      if (m_owner) m_cnt1 = (m_cnt1 + 1) % (1 << CW);
      else         m_cnt0 = (m_cnt0 + 1) % (1 << CW);
      m_held = 0;
    end
    if (grant) begin
      r       = alu_fn(ec, es, ea, eb);
      m_held  = 1;
      m_owner = g;
      m_prio  = !g;
      m_err   = (ec > 5'd9);
      m_data  = m_err ? 32'd0 : r;
      m_zero  = !m_err && (r == 32'd0);
    end
    @(negedge clk);
  endtask

  // sel0: 0 = sub 9-9, 1 = add 5+7 ; sel1: 0 = or 3|4, 1 = illegal 01111 on 1,1
  task automatic set_ops(bit sel0, bit sel1);
    c0 = sel0 ? 5'd0 : 5'd1; s0 = 1'b1;
    a0 = sel0 ? 32'd5 : 32'd9; b0 = sel0 ? 32'd7 : 32'd9;
    c1 = sel1 ? 5'b01111 : 5'd3; s1 = 1'b0;
    a1 = sel1 ? 32'd1 : 32'd3; b1 = sel1 ? 32'd1 : 32'd4;
  endtask

  typedef struct {
    logic [1:0]  vld, rr;
    bit          sel0, sel1;
    logic [1:0]  e_rdy, e_vld;
    logic [31:0] e_data;
    bit          e_zero, e_err;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{2'b11, 2'b11, 0, 0, 2'b01, 2'b00, 32'd0,  0, 0};
    tbl[1]  = '{2'b11, 2'b11, 0, 0, 2'b10, 2'b01, 32'd0,  1, 0};
    tbl[2]  = '{2'b11, 2'b11, 0, 0, 2'b01, 2'b10, 32'd7,  0, 0};
    tbl[3]  = '{2'b11, 2'b11, 0, 0, 2'b10, 2'b01, 32'd0,  1, 0};
    tbl[4]  = '{2'b00, 2'b11, 0, 0, 2'b00, 2'b10, 32'd7,  0, 0};
    tbl[5]  = '{2'b01, 2'b00, 1, 0, 2'b01, 2'b00, 32'd0,  0, 0};
    tbl[6]  = '{2'b00, 2'b01, 1, 0, 2'b00, 2'b01, 32'd12, 0, 0};
    tbl[7]  = '{2'b10, 2'b00, 1, 0, 2'b10, 2'b00, 32'd0,  0, 0};
    for (int i = 8; i < 13; i++)
      tbl[i] = '{2'b01, 2'b00, 1, 0, 2'b00, 2'b10, 32'd7, 0, 0};
    tbl[13] = '{2'b01, 2'b10, 1, 0, 2'b01, 2'b10, 32'd7,  0, 0};
    tbl[14] = '{2'b00, 2'b10, 1, 0, 2'b00, 2'b01, 32'd12, 0, 0};
    tbl[15] = '{2'b00, 2'b10, 1, 0, 2'b00, 2'b01, 32'd12, 0, 0};
    tbl[16] = '{2'b00, 2'b01, 1, 0, 2'b00, 2'b01, 32'd12, 0, 0};
    tbl[17] = '{2'b10, 2'b00, 1, 1, 2'b10, 2'b00, 32'd0,  0, 0};
    tbl[18] = '{2'b10, 2'b10, 1, 0, 2'b10, 2'b10, 32'd0,  0, 1};
    tbl[19] = '{2'b00, 2'b10, 1, 0, 2'b00, 2'b10, 32'd7,  0, 0};

    // Reset held with requests pending
    rst_n = 1'b0; vld = 2'b11; rr = 2'b11; set_ops(0, 0);
    model_reset();
    @(negedge clk); #1;
    chk("rst_req_ready", 32'(rdy), 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      vld = tbl[i].vld; rr = tbl[i].rr; set_ops(tbl[i].sel0, tbl[i].sel1);
      #1;
      chk($sformatf("row%0d_ready", i), 32'(rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d_valid", i), 32'(rsp_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld != 2'b00) begin
        chk($sformatf("row%0d_data", i), rsp_data, tbl[i].e_data);
        chk($sformatf("row%0d_zero", i), 32'(rsp_zero), 32'(tbl[i].e_zero));
        chk($sformatf("row%0d_err", i), 32'(rsp_err), 32'(tbl[i].e_err));
      end
      run_cycle();
    end
    chk("tbl_cnt0", 32'(cnt0), 32'd4);
    chk("tbl_cnt1", 32'(cnt1), 32'd5);

    // Reset mid-operation
    vld = 2'b01; rr = 2'b00; set_ops(1, 0);
    run_cycle();
    vld = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
    chk("midrst_cnt0", 32'(cnt0), 32'd0);
    chk("midrst_cnt1", 32'(cnt1), 32'd0);
    chk("midrst_req_ready", 32'(rdy), 32'd0);
    chk("midrst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Counter wrap: 16 back-to-back req0 ops starting on the first edge after reset
    vld = 2'b01; rr = 2'b01; set_ops(1, 0);
    for (int i = 0; i < 16; i++) run_cycle();
    vld = 2'b00;
    run_cycle();
    #1 chk("wrap_cnt0", 32'(cnt0), 32'd0);

    // Random traffic; a requester holds its operation until it is accepted
    for (int n = 0; n < 400; n++) begin
      if (!(vld[0] && !last_rdy[0])) begin
        vld[0] = ($urandom_range(0, 3) != 0);
        c0 = 5'($urandom_range(0, 11)); s0 = 1'($urandom);
        a0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
        b0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      end
      if (!(vld[1] && !last_rdy[1])) begin
        vld[1] = ($urandom_range(0, 3) != 0);
        c1 = 5'($urandom_range(0, 15)); s1 = 1'($urandom);
        a1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
        b1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      end
      rr = 2'($urandom_range(0, 3));
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one combinational 32-bit ALU between two requesters: the main execute path (port 0) and the branch/compare unit (port 1). Each requester presents an operation with a valid/ready handshake. A round-robin arbiter grants one operation per cycle to the shared ALU. The result is captured in a response register and held until the owning requester accepts it. The block sits between the requesters and the ALU instance; the ALU itself stays outside this block.

## Interface
- WIDTH, 32, operand/result width (fixed at 32 for the current datapath)
- CNT_W, 16, width of the per-requester completed-operation counters

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous reset, active-low
- req_valid  in  2  bit i: requester i has an operation pending
- req_ready  out  2  bit i: operation of requester i accepted this cycle
- req0_ctrl, req1_ctrl  in  5  ALU operation code per requester
- req0_sign, req1_sign  in  1  signed-mode flag per requester
- req0_in1, req0_in2, req1_in1, req1_in2  in  WIDTH  operands
- alu_ctrl  out  5  to ALU operation-code input
- alu_sign  out  1  to ALU sign input
- alu_in1, alu_in2  out  WIDTH  to ALU operand inputs
- alu_out  in  WIDTH  from ALU result
- alu_zero  in  1  from ALU zero flag
- rsp_valid  out  2  bit i: held response belongs to requester i (one-hot or zero)
- rsp_ready  in  2  bit i: requester i takes its response
- rsp_data  out  WIDTH  registered result
- rsp_zero  out  1  registered zero flag
- rsp_err  out  1  registered illegal-opcode flag
- done_cnt0, done_cnt1  out  CNT_W  responses delivered per requester

## Operation
- States:
  - IDLE: no response held.
  - RESP: a response is held for requester `owner`.
- A slot can accept when the state is IDLE, or when the state is RESP and `rsp_ready[owner]` is 1 in that cycle.
- Arbitration (only in a slot that can accept):
  - If only one of `req_valid[0]` or `req_valid[1]` is 1, that requester wins.
  - If both are 1, the requester named by the priority pointer `prio` wins.
  - After every grant, `prio` switches to the requester that did not win.
- Grant cycle:
  - The granted requester's ctrl, sign, in1 and in2 drive the `alu_*` outputs combinationally.
  - `req_ready[g]`=1 for the granted requester only.
  - At the clock edge: `rsp_data` ← `alu_out`, `rsp_zero` ← `alu_zero`, `owner` ← g, state → RESP.
- Legal opcodes are 5'b00000–5'b01001 (add, sub, and, or, xor, nor, sll, srl, sra, slt).
  - For any other code, the operation is still granted and consumed.
  - The registered result is then `rsp_data`=0, `rsp_zero`=0, `rsp_err`=1. `alu_out` is ignored.
  - For legal codes, `rsp_err`=0.
- No grant in a cycle: `alu_ctrl`=0, `alu_sign`=0, `alu_in1`=0, `alu_in2`=0, and `req_ready`=0.
- Response: `rsp_valid[owner]`=1 while in RESP. The data, zero and err outputs stay stable until the handshake completes.
- Handshake complete (`rsp_valid[i]` & `rsp_ready[i]`):
  - `done_cnt<i>` increments by 1 and wraps from 2^CNT_W−1 to 0.
  - If a new grant occurs in the same cycle, the state stays RESP with the new owner and data. Otherwise the state → IDLE.
- `rsp_ready` from the non-owning requester is ignored.
- A requester must hold its ctrl, sign and operands stable while `req_valid` is high and `req_ready` is low.

## Timing
- Latency: request accepted in cycle N; response valid from cycle N+1.
- Sustained throughput: one operation per cycle when the owner asserts `rsp_ready` in the cycle the response appears.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Reset (asynchronous, on `rst_n`=0, including mid-operation):
  - State IDLE, `prio`=0, owner=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_zero`=0, `rsp_err`=0, `done_cnt0`=0, `done_cnt1`=0.
  - `req_ready`=0 and `alu_*`=0 while reset is held.
  - Any held response is discarded and not counted.
- The first edge after `rst_n` rises can register a grant.

## Test plan
- Single add: req0 ctrl=00000, sign=1, in1=5, in2=7 (ALU model returns 12) → `req_ready`=01 in that cycle; next cycle `rsp_valid`=01, `rsp_data`=12, `rsp_zero`=0; with `rsp_ready`=01, `done_cnt0`=1.
- Contention after reset: both valid, req0 sub 9−9, req1 or 3|4, `rsp_ready` held 11 → grant order 0,1,0,1; responses 0 (`rsp_zero`=1), 7, 0, 7, on consecutive cycles.
- Backpressure: response for req1 held with `rsp_ready`=00 for 5 cycles while req0 is valid → `rsp_data`/`rsp_valid`=10 stable and `req_ready`=00 throughout; raising `rsp_ready[1]` grants req0 in that same cycle.
- Wrong-owner ready: owner=0, `rsp_ready`=10 → response held, no counter change.
- Illegal opcode: req1 ctrl=01111, in1=1, in2=1 → `rsp_err`=1, `rsp_data`=0, `rsp_zero`=0, `done_cnt1` increments; next legal op clears `rsp_err`.
- Reset mid-operation and wrap: assert `rst_n`=0 while in RESP → all outputs zero immediately, state IDLE. Separately, with CNT_W=4, complete 16 req0 ops → `done_cnt0` wraps to 0.
